alu_seq: RTL and testbench

//  Parametrised, registered successor of the 32-bit combinational ALU. Accepts one

---
 rtl/alu_seq_if.sv | 30 +++
 rtl/alu_seq.sv | 196 +++++++++++++++++++
 tb/tb_alu_seq.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// Request/response bundle between the decode stage (master) and the sequential ALU (slave).
// A transfer on either side happens on a rising clk edge where valid and ready are both high.
interface alu_seq_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             mode;
    logic [2:0]       operation;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry_flag;
    logic             zero_flag;
    logic             sign_flag;
    logic             overflow_flag;

    modport master (
        output in_valid, a, b, mode, operation, cin, out_ready,
        input  in_ready, out_valid, result, carry_flag, zero_flag, sign_flag, overflow_flag
    );

    modport slave (
        input  in_valid, a, b, mode, operation, cin, out_ready,
        output in_ready, out_valid, result, carry_flag, zero_flag, sign_flag, overflow_flag
    );
endinterface

// File: rtl/alu_seq.sv
// Registered ALU: single-cycle arithmetic/logic ops, iterative shifts of up to SHIFT_STEP bits
// per cycle, result and C/Z/S/V flags held in DONE until the consumer takes them.
module alu_seq #(
    parameter int WIDTH      = 32,
    parameter int SHIFT_STEP = 1,
    parameter int SHW        = $clog2(WIDTH)
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_seq_if.slave   bus,
    output logic [1:0] o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [SHW:0]   STEP  = (SHW + 1)'(SHIFT_STEP);
    localparam logic [WIDTH:0] ONE_X = {{WIDTH{1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] LSB = {{(WIDTH - 1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MSB = {1'b1, {(WIDTH - 1){1'b0}}};

    state_t           r_state;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_res;
    logic             r_c;
    logic             r_z;
    logic             r_s;
    logic             r_v;
    logic [SHW-1:0]   r_rem;
    logic [1:0]       r_sop;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_res;
    logic             w_bsign;
    logic             w_arith;
    logic             w_c;
    logic             w_v;
    logic             w_is_shift;

    logic [SHW:0]     w_k;
    logic [SHW-1:0]   w_rem_next;
    logic             w_rc;
    logic             w_lc;
    logic [WIDTH-1:0] w_shres;
    logic             w_shc;

    // Single-cycle datapath; w_bsign is the sign of the effective addend B'.
    always_comb begin
        w_sum   = '0;
        w_res   = '0;
        w_bsign = 1'b0;
        w_arith = 1'b0;
        if (!bus.mode) begin
            case (bus.operation)
                3'b000: begin
                    w_sum   = {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, bus.cin};
                    w_bsign = bus.b[WIDTH-1];
                    w_arith = 1'b1;
                end
                3'b010: w_res = bus.b;
                3'b011: begin
                    w_sum   = {1'b0, bus.a} + {1'b0, ~bus.b} + ONE_X;
                    w_bsign = ~bus.b[WIDTH-1];
                    w_arith = 1'b1;
                end
                3'b100: begin
                    w_sum   = {1'b0, bus.a} + ONE_X;
                    w_arith = 1'b1;
                end
                default: w_res = '0;
            endcase
            if (w_arith) begin
                w_res = w_sum[WIDTH-1:0];
            end
        end else begin
            case (bus.operation)
                3'b000:  w_res = bus.a & bus.b;
                3'b001:  w_res = bus.a | bus.b;
                3'b010:  w_res = bus.a ^ bus.b;
                3'b011:  w_res = ~bus.a;
                default: w_res = bus.a;
            endcase
        end
    end

    assign w_c        = w_arith & w_sum[WIDTH];
    assign w_v        = w_arith & (bus.a[WIDTH-1] == w_bsign) & (w_res[WIDTH-1] != bus.a[WIDTH-1]);
    assign w_is_shift = bus.mode & bus.operation[2] & ~(bus.operation[1] & bus.operation[0]);

    // Each SHIFT cycle moves min(SHIFT_STEP, remaining) bits; carry is the last bit to leave.
    assign w_k        = ({1'b0, r_rem} < STEP) ? {1'b0, r_rem} : STEP;
    assign w_rem_next = r_rem - w_k[SHW-1:0];
    assign w_rc       = |(r_res & (LSB << (w_k - 1'b1)));
    assign w_lc       = |(r_res & (MSB >> (w_k - 1'b1)));

    always_comb begin
        w_shres = r_res;
        w_shc   = 1'b0;
        case (r_sop)
            2'd0: begin
                w_shres = r_res >> w_k;
                w_shc   = w_rc;
            end
            2'd1: begin
                w_shres = r_res << w_k;
                w_shc   = w_lc;
            end
            2'd2: begin
                w_shres = $unsigned($signed(r_res) >>> w_k);
                w_shc   = w_rc;
            end
            default: begin
                w_shres = r_res;
                w_shc   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_res       <= '0;
            r_c         <= 1'b0;
            r_z         <= 1'b0;
            r_s         <= 1'b0;
            r_v         <= 1'b0;
            r_rem       <= '0;
            r_sop       <= 2'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_in_ready <= 1'b0;
                        if (w_is_shift) begin
                            r_res   <= bus.a;
                            r_rem   <= bus.b[SHW-1:0];
                            r_sop   <= bus.operation[1:0];
                            r_c     <= 1'b0;
                            r_v     <= 1'b0;
                            r_state <= S_SHIFT;
                        end else begin
                            r_res       <= w_res;
                            r_c         <= w_c;
                            r_v         <= w_v;
                            r_z         <= (w_res == '0);
                            r_s         <= w_res[WIDTH-1];
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end
                    end
                end
                S_SHIFT: begin
                    r_res <= w_shres;
                    r_rem <= w_rem_next;
                    if (w_k != '0) begin
                        r_c <= w_shc;
                    end
                    if (w_rem_next == '0) begin
                        r_z         <= (w_shres == '0);
                        r_s         <= w_shres[WIDTH-1];
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready      = r_in_ready;
    assign bus.out_valid     = r_out_valid;
    assign bus.result        = r_res;
    assign bus.carry_flag    = r_c;
    assign bus.zero_flag     = r_z;
    assign bus.sign_flag     = r_s;
    assign bus.overflow_flag = r_v;
    assign o_dbg_state       = r_state;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: a vector table run on SHIFT_STEP=1 and SHIFT_STEP=4 instances,
// plus hand-written backpressure and mid-shift reset sequences.
module tb_alu_seq;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(W)) bus1 ();
    alu_seq_if #(.WIDTH(W)) bus4 ();
    logic [1:0] dbg1;
    logic [1:0] dbg4;

    alu_seq #(.WIDTH(W), .SHIFT_STEP(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1.slave), .o_dbg_state(dbg1)
    );
    alu_seq #(.WIDTH(W), .SHIFT_STEP(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .bus(bus4.slave), .o_dbg_state(dbg4)
    );

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic         mode;
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] res;
        logic         c, z, s, v;
        int           lat1;
        int           lat4;
        string        name;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add_vec(input string name, input logic mode, input logic [2:0] op,
                           input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                           input logic [W-1:0] res, input logic c, input logic z,
                           input logic s, input logic v, input int lat1, input int lat4);
        vec_t t;
        t.name = name; t.mode = mode; t.op = op; t.a = a; t.b = b; t.cin = cin;
        t.res = res; t.c = c; t.z = z; t.s = s; t.v = v; t.lat1 = lat1; t.lat4 = lat4;
        vecs.push_back(t);
    endtask

    task automatic drive_idle();
        bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.mode = 1'b0;
        bus1.operation = 3'b000; bus1.cin = 1'b0; bus1.out_ready = 1'b1;
        bus4.in_valid = 1'b0; bus4.a = '0; bus4.b = '0; bus4.mode = 1'b0;
        bus4.operation = 3'b000; bus4.cin = 1'b0; bus4.out_ready = 1'b1;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge clk);
        while (!(bus1.in_ready && bus4.in_ready) && n < 50) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Both instances receive the same request; latency counts clock edges from the accept edge.
    task automatic run_vec(input vec_t t);
        int n, l1, l4;
        bit g1, g4;
        logic [W+3:0] o1, o4, e;
        wait_ready();
        check({t.name, " in_ready"}, {62'd0, bus1.in_ready, bus4.in_ready}, 64'd3);
        bus1.mode = t.mode; bus1.operation = t.op; bus1.a = t.a; bus1.b = t.b; bus1.cin = t.cin;
        bus4.mode = t.mode; bus4.operation = t.op; bus4.a = t.a; bus4.b = t.b; bus4.cin = t.cin;
        bus1.in_valid = 1'b1;
        bus4.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus1.in_valid = 1'b0;
        bus4.in_valid = 1'b0;
        n = 1; g1 = 1'b0; g4 = 1'b0; l1 = -1; l4 = -1; o1 = '0; o4 = '0;
        while (!(g1 && g4) && n <= 60) begin
            if (!g1 && bus1.out_valid) begin
                g1 = 1'b1; l1 = n;
                o1 = {bus1.result, bus1.carry_flag, bus1.zero_flag, bus1.sign_flag, bus1.overflow_flag};
            end
            if (!g4 && bus4.out_valid) begin
                g4 = 1'b1; l4 = n;
                o4 = {bus4.result, bus4.carry_flag, bus4.zero_flag, bus4.sign_flag, bus4.overflow_flag};
            end
            if (!(g1 && g4)) begin
                @(posedge clk);
                #1;
                n++;
            end
        end
        e = {t.res, t.c, t.z, t.s, t.v};
        check({t.name, " step1 result+CZSV"}, 64'(o1), 64'(e));
        check({t.name, " step4 result+CZSV"}, 64'(o4), 64'(e));
        check({t.name, " step1 latency"}, 64'(l1), 64'(t.lat1));
        check({t.name, " step4 latency"}, 64'(l4), 64'(t.lat4));
    endtask

    logic [W+3:0] hold_exp;

    initial begin
        drive_idle();
        //       name           mode op      a             b             cin res           C     Z     S     V   l1  l4
        add_vec("add_ovf",      1'b0, 3'b000, 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b0, 1'b1, 1'b1, 1, 1);
        add_vec("add_cin_wrap", 1'b0, 3'b000, 32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0, 1, 1);
        add_vec("add_neg_ovf",  1'b0, 3'b000, 32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b1, 1, 1);
        add_vec("sub_eq",       1'b0, 3'b011, 32'h00000005, 32'h00000005, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0, 1, 1);
        add_vec("sub_borrow",   1'b0, 3'b011, 32'h00000000, 32'h00000001, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1);
        add_vec("sub_ovf_cin",  1'b0, 3'b011, 32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b0, 1'b1, 1, 1);
        add_vec("mov",          1'b0, 3'b010, 32'hAAAA5555, 32'h12345678, 1'b1, 32'h12345678, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1);
        add_vec("inc_ovf",      1'b0, 3'b100, 32'h7FFFFFFF, 32'h00000009, 1'b1, 32'h80000000, 1'b0, 1'b0, 1'b1, 1'b1, 1, 1);
        add_vec("inc_wrap",     1'b0, 3'b100, 32'hFFFFFFFF, 32'h00000000, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0, 1, 1);
        add_vec("arith_op001",  1'b0, 3'b001, 32'hFFFFFFFF, 32'h00000001, 1'b1, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b0, 1, 1);
        add_vec("arith_op111",  1'b0, 3'b111, 32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b0, 1, 1);
        add_vec("and",          1'b1, 3'b000, 32'hF0F0F0F0, 32'hFF00FF00, 1'b1, 32'hF000F000, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1);
        add_vec("or",           1'b1, 3'b001, 32'h0F0F0000, 32'h000000F0, 1'b0, 32'h0F0F00F0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1);
        add_vec("xor_zero",     1'b1, 3'b010, 32'hAAAAAAAA, 32'hAAAAAAAA, 1'b0, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b0, 1, 1);
        add_vec("not",          1'b1, 3'b011, 32'h0000FFFF, 32'h00000000, 1'b0, 32'hFFFF0000, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1);
        add_vec("nop",          1'b1, 3'b111, 32'h80000001, 32'h0000001F, 1'b0, 32'h80000001, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1);
        add_vec("sra_4",        1'b1, 3'b110, 32'h80000010, 32'h00000004, 1'b0, 32'hF8000001, 1'b0, 1'b0, 1'b1, 1'b0, 5, 2);
        add_vec("sll_1",        1'b1, 3'b101, 32'hC0000000, 32'h00000001, 1'b0, 32'h80000000, 1'b1, 1'b0, 1'b1, 1'b0, 2, 2);
        add_vec("sll_0",        1'b1, 3'b101, 32'hC0000000, 32'h00000000, 1'b0, 32'hC0000000, 1'b0, 1'b0, 1'b1, 1'b0, 2, 2);
        add_vec("srl_3",        1'b1, 3'b100, 32'h0000000F, 32'h00000003, 1'b0, 32'h00000001, 1'b1, 1'b0, 1'b0, 1'b0, 4, 2);
        add_vec("srl_31_hib",   1'b1, 3'b100, 32'hC0000000, 32'hFFFFFFFF, 1'b0, 32'h00000001, 1'b1, 1'b0, 1'b0, 1'b0, 32, 9);
        add_vec("sra_5_pos",    1'b1, 3'b110, 32'h7FFFFFF0, 32'h00000005, 1'b0, 32'h03FFFFFF, 1'b1, 1'b0, 1'b0, 1'b0, 6, 3);
        add_vec("sra_31_neg",   1'b1, 3'b110, 32'h80000000, 32'h0000001F, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 1'b0, 32, 9);

        // Reset state
        #1 rst_n = 1'b0;
        #2;
        check("reset dut1 ready/valid/result/flags",
              64'({bus1.in_ready, bus1.out_valid, bus1.result, bus1.carry_flag, bus1.zero_flag,
                   bus1.sign_flag, bus1.overflow_flag}), 64'({1'b1, 1'b0, 36'd0}));
        check("reset dut4 ready/valid/result/flags",
              64'({bus4.in_ready, bus4.out_valid, bus4.result, bus4.carry_flag, bus4.zero_flag,
                   bus4.sign_flag, bus4.overflow_flag}), 64'({1'b1, 1'b0, 36'd0}));
        check("reset state idle", 64'({dbg1, dbg4}), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Backpressure: result held in DONE, requests ignored while busy
        wait_ready();
        bus1.out_ready = 1'b0;
        bus1.mode = 1'b0; bus1.operation = 3'b000; bus1.a = 32'h7FFFFFFF; bus1.b = 32'h1; bus1.cin = 1'b0;
        bus1.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus1.in_valid = 1'b0;
        hold_exp = {32'h80000000, 1'b0, 1'b0, 1'b1, 1'b1};
        check("bp out_valid after accept", 64'(bus1.out_valid), 64'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus1.mode = 1'b0; bus1.operation = 3'b010; bus1.b = 32'hDEADBEEF;
            bus1.in_valid = 1'b1;
            @(posedge clk);
            #1;
            check("bp held result+CZSV",
                  64'({bus1.result, bus1.carry_flag, bus1.zero_flag, bus1.sign_flag, bus1.overflow_flag}),
                  64'(hold_exp));
            check("bp in_ready/out_valid", 64'({bus1.in_ready, bus1.out_valid}), 64'b01);
        end
        check("bp state done", 64'(dbg1), 64'd2);
        @(negedge clk);
        bus1.in_valid = 1'b0;
        bus1.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp release to idle", 64'({bus1.in_ready, bus1.out_valid, dbg1}), 64'b10_00);
        @(posedge clk);
        #1;
        check("bp no queued op", 64'({bus1.out_valid, bus1.result}), 64'({1'b0, 32'h80000000}));

        // Reset in the middle of a long shift
        wait_ready();
        bus1.mode = 1'b1; bus1.operation = 3'b101; bus1.a = 32'hFFFFFFFF; bus1.b = 32'd20;
        bus1.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus1.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        check("rst mid-shift in SHIFT", 64'(dbg1), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rst async out_valid/result", 64'({bus1.out_valid, bus1.result}), 64'd0);
        check("rst async ready/state", 64'({bus1.in_ready, dbg1}), 64'b1_00);
        @(negedge clk);
        rst_n = 1'b1;
        begin
            vec_t t;
            t.name = "add_after_rst"; t.mode = 1'b0; t.op = 3'b000; t.a = 32'd3; t.b = 32'd4; t.cin = 1'b1;
            t.res = 32'd8; t.c = 1'b0; t.z = 1'b0; t.s = 1'b0; t.v = 1'b0; t.lat1 = 1; t.lat4 = 1;
            run_vec(t);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", n_errors);
        $fatal(1, "timeout");
    end
endmodule
